// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues a single outstanding instruction
// memory request, and holds the returned word until decode accepts it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | request for PCF outstanding on the memory port
// READY   | InstrF holds the instruction at PCF, waiting for decode
// DISCARD | redirected while a request was in flight; stale ack pending
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          INSTR_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   StallF,
    input  logic                   PCSrcD,
    input  logic [31:0]            PCBranchD,
    input  logic                   JumpD,
    input  logic [31:0]            PCJumpD,
    output logic                   IMemReq,
    output logic [31:0]            IMemAddr,
    input  logic                   IMemAck,
    input  logic [INSTR_WIDTH-1:0] IMemRdata,
    output logic [INSTR_WIDTH-1:0] InstrF,
    output logic [31:0]            PCPlus4F,
    output logic [31:0]            PCF,
    output logic                   InstrValidF,
    output logic                   FetchBusy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        READY   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [31:0]            pc_nx, addr_nx;
    logic [INSTR_WIDTH-1:0] instr_nx;
    logic                   redirect;
    logic [31:0]            target;

    // Decode redirects only count when decode is actually advancing.
    assign redirect = ~StallF & (JumpD | PCSrcD);
    assign target   = (JumpD ? PCJumpD : PCBranchD) & ~32'h3;

    assign PCPlus4F    = PCF + 32'd4;
    assign IMemReq     = (state != READY);
    assign InstrValidF = (state == READY);
    assign FetchBusy   = ~InstrValidF;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            PCF      <= RESET_PC;
            IMemAddr <= RESET_PC;
            InstrF   <= '0;
        end else begin
            state    <= state_nx;
            PCF      <= pc_nx;
            IMemAddr <= addr_nx;
            InstrF   <= instr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = PCF;
        addr_nx  = IMemAddr;
        instr_nx = InstrF;
        unique case (state)
            FETCH: begin
                if (IMemAck) begin
                    if (redirect) begin
                        pc_nx   = target;
                        addr_nx = target;
                    end else begin
                        instr_nx = IMemRdata;
                        state_nx = READY;
                    end
                end else if (redirect) begin
                    // Address stays on the stale request until its ack drains.
                    pc_nx    = target;
                    state_nx = DISCARD;
                end
            end
            READY: begin
                // Acks here are protocol errors and are deliberately ignored.
                if (!StallF) begin
                    pc_nx    = redirect ? target : PCPlus4F;
                    addr_nx  = redirect ? target : PCPlus4F;
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                if (IMemAck) begin
                    pc_nx    = redirect ? target : PCF;
                    addr_nx  = redirect ? target : PCF;
                    state_nx = FETCH;
                end else if (redirect) begin
                    pc_nx = target;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected (PC, instruction)
// pairs; a monitor pops one each time the fetch stage presents a new word.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        StallF, PCSrcD, JumpD, IMemAck;
    logic [31:0] PCBranchD, PCJumpD, IMemRdata;
    logic        IMemReq, InstrValidF, FetchBusy;
    logic [31:0] IMemAddr, InstrF, PCPlus4F, PCF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic prev_valid = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .INSTR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .IMemRdata(IMemRdata), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .PCF(PCF), .InstrValidF(InstrValidF), .FetchBusy(FetchBusy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a zero-latency ack for the outstanding request at pc.
    task automatic ack_fetch(input logic [31:0] pc, input logic [31:0] data);
        check("req_addr", IMemAddr, pc);
        check("req_on", {31'd0, IMemReq}, 32'd1);
        check("busy_fetch", {31'd0, FetchBusy}, 32'd1);
        IMemAck   = 1'b1;
        IMemRdata = data;
        exp_q.push_back('{pc, data});
        tick();
        IMemAck   = 1'b0;
        IMemRdata = '0;
        check("valid_ready", {31'd0, InstrValidF}, 32'd1);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
        end else begin
            if (InstrValidF && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", PCF, InstrF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc", PCF, e.pc);
                    check("sb_instr", InstrF, e.instr);
                end
            end
            prev_valid = InstrValidF;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = '0; PCJumpD = '0; IMemAck = 1'b0; IMemRdata = '0;
        tick(); tick();
        check("rst_pc", PCF, 32'h0);
        check("rst_addr", IMemAddr, 32'h0);
        check("rst_instr", InstrF, 32'h0);
        check("rst_valid", {31'd0, InstrValidF}, 32'd0);
        check("rst_req", {31'd0, IMemReq}, 32'd1);
        RST = 1'b0;

        // Boot fetch acked in its first cycle.
        ack_fetch(32'h0, 32'h2008_0005);
        check("boot_instr", InstrF, 32'h2008_0005);
        check("boot_pc4", PCPlus4F, 32'h4);
        check("boot_req_off", {31'd0, IMemReq}, 32'd0);

        // Sequential fetches, one instruction per two cycles.
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_valid_lo", {31'd0, InstrValidF}, 32'd0);
            ack_fetch(32'(4 * i), 32'hA000_0000 + 32'(i));
        end

        // Stall in READY: stray ack and a jump must both be ignored.
        StallF = 1'b1; IMemAck = 1'b1; IMemRdata = 32'hBAD0_BAD0;
        tick();
        IMemAck = 1'b0; IMemRdata = '0;
        check("stall_pc", PCF, 32'hC);
        check("stall_instr", InstrF, 32'hA000_0003);
        JumpD = 1'b1; PCJumpD = 32'h300;
        tick();
        JumpD = 1'b0;
        check("stall_jump_pc", PCF, 32'hC);
        check("stall_valid", {31'd0, InstrValidF}, 32'd1);
        tick();
        check("stall_req", {31'd0, IMemReq}, 32'd0);
        check("stall_instr2", InstrF, 32'hA000_0003);
        StallF = 1'b0;
        tick();
        check("resume_pc", PCF, 32'h10);

        // Branch while the request is pending; stale ack arrives two cycles later.
        PCSrcD = 1'b1; PCBranchD = 32'h40;
        tick();
        PCSrcD = 1'b0;
        check("disc_pc", PCF, 32'h40);
        check("disc_addr", IMemAddr, 32'h10);
        check("disc_req", {31'd0, IMemReq}, 32'd1);
        tick();
        check("disc_addr_hold", IMemAddr, 32'h10);
        IMemAck = 1'b1; IMemRdata = 32'hDEAD_BEEF;
        tick();
        IMemAck = 1'b0; IMemRdata = '0;
        check("disc_valid", {31'd0, InstrValidF}, 32'd0);
        ack_fetch(32'h40, 32'hB000_0040);

        // Redirects inside DISCARD, including one coincident with the ack.
        tick();
        JumpD = 1'b1; PCJumpD = 32'h500;
        tick();
        JumpD = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h600;
        tick();
        PCSrcD = 1'b0;
        check("disc2_pc", PCF, 32'h600);
        check("disc2_addr", IMemAddr, 32'h44);
        JumpD = 1'b1; PCJumpD = 32'h700; IMemAck = 1'b1; IMemRdata = 32'hDEAD_0044;
        tick();
        JumpD = 1'b0; IMemAck = 1'b0; IMemRdata = '0;
        check("disc2_exit_pc", PCF, 32'h700);
        ack_fetch(32'h700, 32'hC000_0700);

        // Jump wins over branch; target low bits are cleared.
        JumpD = 1'b1; PCSrcD = 1'b1; PCJumpD = 32'h100; PCBranchD = 32'h200;
        tick();
        PCSrcD = 1'b0;
        check("prio_pc", PCF, 32'h100);
        PCJumpD = 32'h103; IMemAck = 1'b1; IMemRdata = 32'hDEAD_0100;
        tick();
        JumpD = 1'b0; IMemAck = 1'b0; IMemRdata = '0;
        check("align_pc", PCF, 32'h100);
        check("align_valid", {31'd0, InstrValidF}, 32'd0);
        ack_fetch(32'h100, 32'hD000_0100);

        // Asynchronous reset mid-request.
        JumpD = 1'b1; PCJumpD = 32'h80;
        tick();
        JumpD = 1'b0;
        check("pre_rst_pc", PCF, 32'h80);
        #2 RST = 1'b1;
        #1;
        check("arst_pc", PCF, 32'h0);
        check("arst_addr", IMemAddr, 32'h0);
        check("arst_req", {31'd0, IMemReq}, 32'd1);
        tick();
        RST = 1'b0;
        ack_fetch(32'h0, 32'hE000_0000);

        // PC wraparound at the top of the address space.
        JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
        tick();
        JumpD = 1'b0;
        check("wrap_pc4", PCPlus4F, 32'h0);
        ack_fetch(32'hFFFF_FFFC, 32'hF000_FFFC);
        tick();
        check("wrap_pc", PCF, 32'h0);
        check("wrap_addr", IMemAddr, 32'h0);

        tick(); tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
